regset_multi: RTL and testbench

Parametrised multi-channel register set for the peripheral register bus. It replicates the single-channel data register with a read-only status mirror across NUM_CH channels and adds per-lane byte-strobed writes. Each channel also gets a sticky write-1-to-clear event flag, a clear-on-read saturating event counter and a maskable interrupt. Reads are registered, and bad accesses are flagged.

---
 rtl/regset_multi.sv | 228 ++++++++++++++++++++++
 tb/tb_regset_multi.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regset_multi.sv
`default_nettype none
// ============================================================================
// Module      : regset_multi
// Description : Multi-channel peripheral register set. Each channel has a
//               byte-strobed DATA register, a read-only SR mirror, a sticky
//               write-1-to-clear event flag pair and a saturating
//               clear-on-read event counter. The global registers are an
//               interrupt enable, a pending view and an ID word. Read data
//               comes back one cycle after the request. Any invalid access
//               raises a one-cycle err pulse.
// Ports       : clk, rst            clock / synchronous active-high reset
//               wr_en, rd_en        write / read strobes
//               addr, wdata, wstrb  byte address, write data, lane enables
//               hw_evt              per-channel hardware event inputs
//               rdata, rvalid       registered read data and its qualifier
//               err                 invalid-access pulse (registered)
//               irq                 OR of enabled pending events
// Revision    : 1.0  initial release
// ============================================================================
module regset_multi #(
    parameter int                 DATA_W     = 32,
    parameter int                 ADDR_W     = 10,
    parameter int                 NUM_CH     = 4,
    parameter logic [DATA_W-1:0]  DATA_RESET = '0,
    parameter int                 CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [NUM_CH-1:0]     hw_evt,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  err,
    output logic                  irq
);

    localparam int c_nbytes = DATA_W / 8;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_data [NUM_CH];
    logic [CNT_W-1:0]  r_cnt  [NUM_CH];
    logic [NUM_CH-1:0] r_st0;       // event seen
    logic [NUM_CH-1:0] r_st1;       // event while already seen
    logic [NUM_CH-1:0] r_irq_en;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic              r_err;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic        w_aligned;
    logic        w_in_range;
    logic        w_glob;
    logic [3:0]  w_ch;
    logic [1:0]  w_reg;
    logic        w_ch_ok;
    logic        w_valid;
    logic        w_ro;
    logic        w_wr_ok;
    logic        w_rd_ok;
    logic        w_err_next;

    assign w_aligned  = (addr[1:0] == 2'b00);
    assign w_in_range = ((addr >> 9) == '0);
    assign w_glob     = addr[8];
    assign w_ch       = addr[7:4];
    assign w_reg      = addr[3:2];
    assign w_ch_ok    = ({1'b0, w_ch} < 5'(NUM_CH));

    // Only the first three words of the global page exist.
    assign w_valid = w_aligned && w_in_range &&
                     (w_glob ? ((w_ch == 4'd0) && (w_reg != 2'd3)) : w_ch_ok);

    // SR/EVT_CNT in a channel page, IRQ_PEND/ID in the global page.
    assign w_ro = w_glob ? (w_reg != 2'd0) : w_reg[0];

    assign w_wr_ok    = wr_en && w_valid && !w_ro;
    assign w_rd_ok    = rd_en && w_valid;
    assign w_err_next = (wr_en && !(w_valid && !w_ro)) || (rd_en && !w_valid);

    // ------------------------------------------------------------------
    // ID word
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_id;

    if (DATA_W == 32) begin : g_id32
        assign w_id = DATA_W'({16'hA5C0, 8'h00, 8'(NUM_CH)});
    end else begin : g_idn
        assign w_id = DATA_W'(8'(NUM_CH));
    end

    // ------------------------------------------------------------------
    // Per-channel registers
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic w_sel;
        logic w_wr_data;
        logic w_wr_stat;
        logic w_rd_cnt;
        logic w_clr0;
        logic w_clr1;

        assign w_sel     = !w_glob && (w_ch == 4'(c));
        assign w_wr_data = w_wr_ok && w_sel && (w_reg == 2'd0);
        assign w_wr_stat = w_wr_ok && w_sel && (w_reg == 2'd2);
        assign w_rd_cnt  = w_rd_ok && w_sel && (w_reg == 2'd3);
        assign w_clr0    = w_wr_stat && wstrb[0] && wdata[0];
        assign w_clr1    = w_wr_stat && wstrb[0] && wdata[1];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_data[c] <= DATA_RESET;
                r_st0[c]  <= 1'b0;
                r_st1[c]  <= 1'b0;
                r_cnt[c]  <= '0;
            end else begin
                if (w_wr_data) begin
                    for (int b = 0; b < c_nbytes; b++) begin
                        if (wstrb[b]) begin
                            r_data[c][8*b +: 8] <= wdata[8*b +: 8];
                        end
                    end
                end
                // A new event beats a simultaneous clear; the overflow
                // flag looks at the flag value from before this edge.
                r_st0[c] <= hw_evt[c] || (r_st0[c] && !w_clr0);
                r_st1[c] <= (hw_evt[c] && r_st0[c]) || (r_st1[c] && !w_clr1);
                // Read returns the old count; the event of the read cycle
                // becomes the first count of the new window.
                if (w_rd_cnt) begin
                    r_cnt[c] <= CNT_W'(hw_evt[c]);
                end else if (hw_evt[c] && (r_cnt[c] != {CNT_W{1'b1}})) begin
                    r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupt enable
    // ------------------------------------------------------------------
    logic w_wr_en_reg;
    assign w_wr_en_reg = w_wr_ok && w_glob && (w_reg == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_en <= '0;
        end else if (w_wr_en_reg) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (wstrb[j/8]) begin
                    r_irq_en[j] <= wdata[j];
                end
            end
        end
    end

    logic [NUM_CH-1:0] w_pend;
    assign w_pend = r_st0 & r_irq_en;
    assign irq    = |w_pend;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_ch_data;
    logic [DATA_W-1:0] w_ch_stat;
    logic [DATA_W-1:0] w_ch_cnt;
    logic [DATA_W-1:0] w_rmux;

    // Channel select as a loop of compares so a 4-bit field never indexes
    // past the end of a smaller channel array.
    always_comb begin
        w_ch_data = '0;
        w_ch_stat = '0;
        w_ch_cnt  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ch == 4'(c)) begin
                w_ch_data = r_data[c];
                w_ch_stat = DATA_W'({r_st1[c], r_st0[c]});
                w_ch_cnt  = DATA_W'(r_cnt[c]);
            end
        end
    end

    always_comb begin
        w_rmux = '0;
        if (w_valid) begin
            if (w_glob) begin
                case (w_reg)
                    2'd0:    w_rmux = DATA_W'(r_irq_en);
                    2'd1:    w_rmux = DATA_W'(w_pend);
                    2'd2:    w_rmux = w_id;
                    default: w_rmux = '0;
                endcase
            end else begin
                case (w_reg)
                    2'd0, 2'd1: w_rmux = w_ch_data;
                    2'd2:       w_rmux = w_ch_stat;
                    default:    w_rmux = w_ch_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rdata  <= rd_en ? w_rmux : '0;
            r_rvalid <= rd_en;
            r_err    <= w_err_next;
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_regset_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_regset_multi
// Description : Self-checking bench for regset_multi with default parameters
//               (four channels, 32-bit data, 16-bit counters). A behavioural
//               model of the register map predicts every response. Directed
//               sequences cover reset values, strobes, bad accesses, events,
//               interrupts and reset during a read. A randomised phase
//               follows.
// Revision    : 1.0  initial release
// ============================================================================
module tb_regset_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  hw_evt;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
    logic        irq;

    regset_multi dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .addr   (addr),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .hw_evt (hw_evt),
        .rdata  (rdata),
        .rvalid (rvalid),
        .err    (err),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: register contents as plain arrays
    // ------------------------------------------------------------------
    logic [31:0] m_data [4];
    bit          m_s0   [4];
    bit          m_s1   [4];
    int          m_cnt  [4];
    logic [3:0]  m_en;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [3:0] m_pend();
        logic [3:0] p;
        for (int c = 0; c < 4; c++) p[c] = m_s0[c] & m_en[c];
        return p;
    endfunction

    function automatic void m_reset();
        for (int c = 0; c < 4; c++) begin
            m_data[c] = 32'h0;
            m_s0[c]   = 0;
            m_s1[c]   = 0;
            m_cnt[c]  = 0;
        end
        m_en = 4'h0;
    endfunction

    // Look up a byte address: legal?, read-only?, current value.
    function automatic void m_decode(input int a, output bit ok, output bit ro,
                                     output logic [31:0] val);
        int ch;
        ok  = 0;
        ro  = 0;
        val = 32'h0;
        if ((a % 4) != 0 || a >= 512) return;
        if (a >= 256) begin
            case (a - 256)
                0: begin ok = 1; val = {28'h0, m_en}; end
                4: begin ok = 1; ro = 1; val = {28'h0, m_pend()}; end
                8: begin ok = 1; ro = 1; val = 32'hA5C0_0004; end
                default: ;
            endcase
            return;
        end
        ch = a / 16;
        if (ch >= 4) return;
        ok = 1;
        case ((a % 16) / 4)
            0: val = m_data[ch];
            1: begin ro = 1; val = m_data[ch]; end
            2: val = {30'h0, m_s1[ch], m_s0[ch]};
            default: begin ro = 1; val = m_cnt[ch]; end
        endcase
    endfunction

    // One bus cycle: drive, predict, clock, update model, compare.
    task automatic step(input bit wr, input bit rd, input int a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input logic [3:0] evt);
        bit          ok, ro, wok;
        logic [31:0] val, e_rdata;
        bit          e_err;
        int          ch, off;
        bit          clr0, clr1, s0_old;

        wr_en  = wr;
        rd_en  = rd;
        addr   = a[9:0];
        wdata  = wd;
        wstrb  = ws;
        hw_evt = evt;

        m_decode(a, ok, ro, val);
        wok     = wr && ok && !ro;
        e_rdata = (rd && ok) ? val : 32'h0;
        e_err   = (wr && !(ok && !ro)) || (rd && !ok);
        ch      = a / 16;
        off     = a % 16;

        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            clr0 = wok && a < 256 && ch == c && off == 8 && ws[0] && wd[0];
            clr1 = wok && a < 256 && ch == c && off == 8 && ws[0] && wd[1];
            s0_old  = m_s0[c];
            m_s0[c] = evt[c] || (m_s0[c] && !clr0);
            m_s1[c] = (evt[c] && s0_old) || (m_s1[c] && !clr1);
            if (rd && ok && a < 256 && ch == c && off == 12)
                m_cnt[c] = evt[c] ? 1 : 0;
            else if (evt[c] && m_cnt[c] < 65535)
                m_cnt[c] = m_cnt[c] + 1;
            if (wok && a < 256 && ch == c && off == 0)
                for (int b = 0; b < 4; b++)
                    if (ws[b]) m_data[c][8*b +: 8] = wd[8*b +: 8];
        end
        if (wok && a == 256 && ws[0]) m_en = wd[3:0];

        #1;
        check("rvalid", rvalid, rd);
        check("rdata", rdata, e_rdata);
        check("err", err, e_err);
        check("irq", irq, |m_pend());
    endtask

    task automatic rd_at(input int a);
        step(0, 1, a, 32'h0, 4'h0, 4'h0);
    endtask

    task automatic wr_at(input int a, input logic [31:0] d, input logic [3:0] s);
        step(1, 0, a, d, s, 4'h0);
    endtask

    task automatic do_reset(input bit rd);
        rst    = 1'b1;
        rd_en  = rd;
        wr_en  = 1'b1;
        addr   = 10'h000;
        wdata  = 32'hFFFF_FFFF;
        wstrb  = 4'hF;
        hw_evt = 4'hF;
        @(posedge clk);
        m_reset();
        #1;
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        check("rst_irq", irq, 0);
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        int a;
        rst = 1'b1; wr_en = 0; rd_en = 0; addr = 0; wdata = 0; wstrb = 0; hw_evt = 0;
        m_reset();
        do_reset(0);

        // Reset values everywhere, then ID.
        for (int x = 0; x < 16; x++) begin
            rd_at(4 * x);
            check("reset_val", rdata, 32'h0);
        end
        rd_at(32'h100); check("reset_irq_en", rdata, 32'h0);
        rd_at(32'h104); check("reset_pend", rdata, 32'h0);
        rd_at(32'h108); check("id", rdata, 32'hA5C0_0004);

        // Byte strobes on channel 2.
        wr_at(32'h20, 32'hAAAA_5555, 4'hF);
        wr_at(32'h20, 32'h1234_5678, 4'b0101);
        rd_at(32'h20); check("ch2_data", rdata, 32'hAA34_5578);
        rd_at(32'h24); check("ch2_sr", rdata, 32'hAA34_5578);

        // Read-only and invalid accesses.
        wr_at(32'h04, 32'hFFFF_FFFF, 4'hF); check("ro_wr_err", err, 1);
        rd_at(32'h00); check("data0_kept", rdata, 32'h0);
        rd_at(32'h40);  check("bad_ch_err", err, 1);   check("bad_ch_data", rdata, 0);
        rd_at(32'h102); check("unalign_err", err, 1);  check("unalign_data", rdata, 0);
        rd_at(32'h200); check("high_err", err, 1);     check("high_data", rdata, 0);

        // Events on channel 1, clear-on-read counter, saturation.
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 4'b0010);
        rd_at(32'h18); check("evt_stat", rdata, 32'h3);
        rd_at(32'h1C); check("evt_cnt", rdata, 32'd3);
        rd_at(32'h1C); check("evt_cnt_clr", rdata, 32'd0);
        for (int k = 0; k < 70000; k++) step(0, 0, 0, 0, 0, 4'b0010);
        rd_at(32'h1C); check("evt_cnt_sat", rdata, 32'hFFFF);

        // Interrupt path on channel 3.
        wr_at(32'h100, 32'h8, 4'hF);
        step(0, 0, 0, 0, 0, 4'b1000); check("irq_rise", irq, 1);
        rd_at(32'h104); check("irq_pend", rdata, 32'h8);
        step(1, 0, 32'h38, 32'h1, 4'hF, 4'b1000); check("irq_set_wins", irq, 1);
        rd_at(32'h38); check("stat_set_wins", rdata[0], 1);
        wr_at(32'h38, 32'h3, 4'hF); check("irq_cleared", irq, 0);

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                if ($urandom_range(0, 3) != 0) a = $urandom_range(0, 16'h4F) & ~3;
                else if ($urandom_range(0, 1) == 0) a = 32'h100 + ($urandom_range(0, 4) * 4);
                else a = $urandom_range(0, 16'h27F);
                step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a,
                     $urandom, 4'($urandom), 4'($urandom & $urandom));
            end
        end

        // Reset coinciding with a read: read dropped, state back to reset.
        wr_at(32'h00, 32'hDEAD_BEEF, 4'hF);
        wr_at(32'h100, 32'hF, 4'hF);
        step(0, 0, 0, 0, 0, 4'hF);
        do_reset(1);
        rd_at(32'h00);  check("post_rst_data0", rdata, 32'h0);
        rd_at(32'h100); check("post_rst_irq_en", rdata, 32'h0);
        for (int x = 0; x < 16; x++) rd_at(4 * x);
        rd_at(32'h104);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
